// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: N masters, round-robin arbitration, address-MSB slave
// decode, bus-error termination for unmapped slots and a no-ack watchdog.
module wb_conbus_rr #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_SLAVES  = 5,
    parameter int unsigned S_ADDR_W  = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*N_MASTERS-1:0]   m_adr_i,
    input  logic [32*N_MASTERS-1:0]   m_dat_i,
    input  logic [4*N_MASTERS-1:0]    m_sel_i,
    input  logic [N_MASTERS-1:0]      m_we_i,
    input  logic [N_MASTERS-1:0]      m_cyc_i,
    input  logic [N_MASTERS-1:0]      m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [N_MASTERS-1:0]      m_ack_o,
    output logic [N_MASTERS-1:0]      m_err_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [N_SLAVES-1:0]       s_cyc_o,
    output logic [N_SLAVES-1:0]       s_stb_o,
    input  logic [32*N_SLAVES-1:0]    s_dat_i,
    input  logic [N_SLAVES-1:0]       s_ack_i,
    output logic [N_MASTERS-1:0]      grant_o
);

    localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(N_MASTERS - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [S_ADDR_W:0] SLOT_LIMIT = (S_ADDR_W + 1)'(N_SLAVES);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [7:0]           wd_q, wd_d;
    logic                 err_q, err_d;

    logic                 granted;
    logic                 gcyc;
    logic                 gstb;
    logic [S_ADDR_W-1:0]  slot;
    logic                 mapped;
    logic                 ack;
    logic                 err_wd;
    logic                 bus_err;

    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        cand;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Next-state: round-robin pick starts one past the last grantee
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= int'(N_MASTERS); i++) begin
            cand = IW'((int'(last_q) + i) % int'(N_MASTERS));
            if (!pick_found && m_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d           = StBusy;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                end
            end
            StBusy: begin
                if (!gcyc) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        // Unmapped slot: err pulse next cycle, then one cycle off before re-evaluating
        err_d = gstb && !mapped && !err_q;
        wd_d  = (!gstb || ack || bus_err) ? 8'd0 : wd_q + 8'd1;
    end

    // Outputs: master-side mux driven purely from the registered grant
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        gcyc    = 1'b0;
        gstb    = 1'b0;
        for (int j = 0; j < int'(N_MASTERS); j++) begin
            if (grant_q[j]) begin
                s_adr_o = m_adr_i[32*j +: 32];
                s_dat_o = m_dat_i[32*j +: 32];
                s_sel_o = m_sel_i[4*j +: 4];
                s_we_o  = m_we_i[j];
                gcyc    = m_cyc_i[j];
                gstb    = m_stb_i[j];
            end
        end
    end

    assign granted = |grant_q;
    assign slot    = s_adr_o[31 -: S_ADDR_W];
    assign mapped  = {1'b0, slot} < SLOT_LIMIT;

    // Slave-side decode; acks from other slots never reach the master
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        ack     = 1'b0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            if (granted && slot == S_ADDR_W'(k)) begin
                s_cyc_o[k] = gcyc;
                s_stb_o[k] = gstb;
                m_dat_o    = s_dat_i[32*k +: 32];
                ack        = s_ack_i[k];
            end
        end
    end

    // A same-cycle ack always wins over any error source
    assign err_wd  = gstb && (wd_q == TIMEOUT_CNT) && !ack;
    assign bus_err = (err_q || err_wd) && !ack;

    assign m_ack_o = grant_q & {N_MASTERS{ack}};
    assign m_err_o = grant_q & {N_MASTERS{bus_err}};
    assign grant_o = grant_q;

endmodule
